cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- 32-bit single-bus CPU datapath: sixteen general registers R0–R15 plus PC, HI, LO, Y, Z (64-bit), MAR, MDR and an input-port register.
- The registers and the ALU exchange data over one shared 32-bit bus.
- An external control unit (or testbench) drives every load enable, every bus-drive select and the ALU opcode each cycle.
- The block is the execution core under the processor control sequencer.

Parameters:
- WIDTH, 32, bus and register width (fixed; not overridden).

Ports:
clock  input  1  rising-edge clock for all registers
clear  input  1  asynchronous, active-low reset (low = reset)
R0in..R15in  input  1 each  load general register from bus
PCin, HIin, LOin, Yin, MARin, InPortIn  input  1 each  load that register (InPortIn loads from in_port_data)
Zin  input  1  load 64-bit Z from ALU result
MDRin  input  1  load MDR
read  input  1  MDR source select: 1 = Mdatain, 0 = bus
incPC  input  1  increment PC
opcode  input  5  ALU operation select
Mdatain  input  32  memory read data
in_port_data  input  32  external input port value
R0out..R15out, PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut  input  1 each  drive that source onto bus
bus_out  output  32  current bus value (combinational)
mar_out  output  32  MAR contents
pc_out  output  32  PC contents

Behaviour:
- Reset: clear low asynchronously zeroes every register, including Z (64-bit) and the input-port register. bus_out, mar_out and pc_out read 0 while clear is low.
- Register loads:
  - Every register loads on the rising clock edge when its enable is high; otherwise it holds.
  - A register loads in the same cycle the bus is driven, so a transfer takes one cycle.
  - Several enables may be high at once; every enabled destination loads the same bus value.
- Bus driving:
  - The bus is a combinational mux; no tri-states.
  - Priority when several out-selects are high, highest first: R0..R15, PC, HI, LO, ZHigh, ZLow, MDR, InPort.
  - With no out-select high, the bus is 0.
- MDR: loads Mdatain when MDRin=1 and read=1; loads the bus when MDRin=1 and read=0.
- PC:
  - PCin=1: PC <= bus. PCin has priority over incPC.
  - PCin=0 and incPC=1: PC <= PC+1, wrapping modulo 2^32.
- ALU:
  - Combinational; A = Y, B = bus. Result is 64-bit; Z <= result on the edge when Zin=1.
  - For 32-bit ops the result is zero-extended (high word 0).
  - Opcodes:
    - 00011 ADD: A+B, wraps mod 2^32, carry discarded.
    - 00100 SUB: A−B, wraps.
    - 00101 AND; 00110 OR.
    - 00111 SHR: A logical right shift by B[4:0].
    - 01000 SHRA: A arithmetic right shift by B[4:0].
    - 01001 SHL: A left shift by B[4:0].
    - 01010 ROR, 01011 ROL: rotate A by B[4:0].
    - 01111 MUL: signed A*B, full 64-bit product (high word in Z[63:32]).
    - 10000 DIV: signed A/B; Z[31:0] = quotient, Z[63:32] = remainder. Division by zero gives Z=0.
    - 10001 NEG: −B. 10010 NOT: ~B.
    - Any other opcode: result 0.
- Z drive: ZLowOut drives Z[31:0]; ZHighOut drives Z[63:32].
- Simultaneous source/destination: a register may drive the bus and load in the same cycle; it captures its own old value (no change).
- Reset mid-operation: all state clears immediately; the next cycle after clear rises behaves as after power-up.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: MUL (01111) and DIV (10000) are implemented as above.
- Undefined: no multiplier or divider hardware; those opcodes yield result 0 like undefined opcodes. All other behaviour is identical.

Test Plan:
- Register load/readback:
  - Mdatain=30, read=1, MDRin=1, one edge; then MDRout=1, R3in=1, one edge.
  - Then R3out=1 -> bus_out=30. Repeat for R7=25 and R4=10.
- ADD: R3out+Yin one edge; R7out, opcode=00011, Zin one edge; ZLowOut+R4in one edge -> R4 reads 55 and ZHighOut bus reads 0.
- PC/MAR:
  - PCout+MARin+incPC one edge from reset -> mar_out=0, pc_out=1.
  - Then PCin with MDRout (MDR=0x00000003) -> pc_out=3.
  - PC=0xFFFFFFFF with incPC -> pc_out=0.
- Shift/rotate: Y=0x80000001, bus=4:
  - SHRA -> 0xF8000000.
  - ROL -> 0x00000018.
  - SHR -> 0x08000000.
- MUL/DIV (ALU_MULDIV_EN defined):
  - Y=−6, bus=4, MUL -> Z=0xFFFFFFFF_FFFFFFE8.
  - Y=17, bus=5, DIV -> ZLow=3, ZHigh=2.
  - DIV by 0 -> Z=0.
- Async reset: clear low between clock edges with registers loaded -> pc_out, mar_out, bus_out (any out-select) read 0 immediately.
- Priority: R2out and MDRout both high -> bus_out equals R2.

Source files
------------

// File: rtl/cpu_datapath_if.sv
// Control and data bundle between the control sequencer (master) and the datapath (slave).
// Rin[i] and Rout[i] are the per-register load and drive strobes for R<i>.
interface cpu_datapath_if #(parameter int WIDTH = 32);
   logic [15:0]      Rin;
   logic [15:0]      Rout;
   logic             PCin, HIin, LOin, Yin, MARin, InPortIn, Zin, MDRin;
   logic             read, incPC;
   logic [4:0]       opcode;
   logic [WIDTH-1:0] Mdatain;
   logic [WIDTH-1:0] in_port_data;
   logic             PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut;
   logic [WIDTH-1:0] bus_out;
   logic [WIDTH-1:0] mar_out;
   logic [WIDTH-1:0] pc_out;

   modport master (
      output Rin, Rout, PCin, HIin, LOin, Yin, MARin, InPortIn, Zin, MDRin,
             read, incPC, opcode, Mdatain, in_port_data,
             PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut,
      input  bus_out, mar_out, pc_out
   );

   modport slave (
      input  Rin, Rout, PCin, HIin, LOin, Yin, MARin, InPortIn, Zin, MDRin,
             read, incPC, opcode, Mdatain, in_port_data,
             PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut,
      output bus_out, mar_out, pc_out
   );
endinterface

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: R0-R15, PC, HI, LO, Y, 64-bit Z, MAR, MDR, input port, ALU.
// Optional macro ALU_MULDIV_EN adds the signed multiplier and divider.
module cpu_datapath #(
   parameter int WIDTH = 32
) (
   input  logic         clock,
   input  logic         clear,
   cpu_datapath_if.slave bus
);

   logic [WIDTH-1:0]   r_reg [16];
   logic [WIDTH-1:0]   pc_reg, hi_reg, lo_reg, y_reg, mar_reg, mdr_reg, inport_reg;
   logic [2*WIDTH-1:0] z_reg;
   logic [WIDTH-1:0]   bus_val;
   logic [2*WIDTH-1:0] alu_result;
   logic [4:0]         shamt;

   // Later assignments override earlier ones, so R0 ends up with highest priority.
   always_comb begin
      bus_val = '0;
      if (bus.InPortOut) bus_val = inport_reg;
      if (bus.MDRout)    bus_val = mdr_reg;
      if (bus.ZLowOut)   bus_val = z_reg[WIDTH-1:0];
      if (bus.ZHighOut)  bus_val = z_reg[2*WIDTH-1:WIDTH];
      if (bus.LOout)     bus_val = lo_reg;
      if (bus.HIout)     bus_val = hi_reg;
      if (bus.PCout)     bus_val = pc_reg;
      for (int i = 15; i >= 0; i--) begin
         if (bus.Rout[i]) bus_val = r_reg[i];
      end
   end

   assign bus.bus_out = bus_val;
   assign bus.mar_out = mar_reg;
   assign bus.pc_out  = pc_reg;
   assign shamt       = bus_val[4:0];

`ifdef ALU_MULDIV_EN
   logic signed [2*WIDTH-1:0] mul_a, mul_b, product;
   logic signed [WIDTH-1:0]   div_a, div_b, quotient, remainder;

   assign mul_a     = {{WIDTH{y_reg[WIDTH-1]}}, y_reg};
   assign mul_b     = {{WIDTH{bus_val[WIDTH-1]}}, bus_val};
   assign product   = mul_a * mul_b;
   assign div_a     = y_reg;
   assign div_b     = bus_val;
   assign quotient  = (div_b == '0) ? '0 : div_a / div_b;
   assign remainder = (div_b == '0) ? '0 : div_a % div_b;
`endif

   always_comb begin
      alu_result = '0;
      case (bus.opcode)
         5'b00011: alu_result[WIDTH-1:0] = y_reg + bus_val;
         5'b00100: alu_result[WIDTH-1:0] = y_reg - bus_val;
         5'b00101: alu_result[WIDTH-1:0] = y_reg & bus_val;
         5'b00110: alu_result[WIDTH-1:0] = y_reg | bus_val;
         5'b00111: alu_result[WIDTH-1:0] = y_reg >> shamt;
         5'b01000: alu_result[WIDTH-1:0] = $unsigned($signed(y_reg) >>> shamt);
         5'b01001: alu_result[WIDTH-1:0] = y_reg << shamt;
         // A zero shift amount makes the 32-position complementary shift yield 0.
         5'b01010: alu_result[WIDTH-1:0] = (y_reg >> shamt) | (y_reg << (6'd32 - {1'b0, shamt}));
         5'b01011: alu_result[WIDTH-1:0] = (y_reg << shamt) | (y_reg >> (6'd32 - {1'b0, shamt}));
`ifdef ALU_MULDIV_EN
         5'b01111: alu_result = product;
         5'b10000: alu_result = {remainder, quotient};
`endif
         5'b10001: alu_result[WIDTH-1:0] = '0 - bus_val;
         5'b10010: alu_result[WIDTH-1:0] = ~bus_val;
         default:  alu_result = '0;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_gpr
         always_ff @(posedge clock or negedge clear) begin
            if (!clear)             r_reg[gi] <= '0;
            else if (bus.Rin[gi])   r_reg[gi] <= bus_val;
         end
      end
   endgenerate

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         pc_reg     <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         y_reg      <= '0;
         mar_reg    <= '0;
         mdr_reg    <= '0;
         inport_reg <= '0;
         z_reg      <= '0;
      end else begin
         if (bus.PCin)          pc_reg <= bus_val;
         else if (bus.incPC)    pc_reg <= pc_reg + 1'b1;
         if (bus.HIin)          hi_reg <= bus_val;
         if (bus.LOin)          lo_reg <= bus_val;
         if (bus.Yin)           y_reg  <= bus_val;
         if (bus.MARin)         mar_reg <= bus_val;
         if (bus.MDRin)         mdr_reg <= bus.read ? bus.Mdatain : bus_val;
         if (bus.InPortIn)      inport_reg <= bus.in_port_data;
         if (bus.Zin)           z_reg <= alu_result;
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: register transfers, PC/MAR, ALU ops, bus priority, async clear.
module tb_cpu_datapath;
   logic clock;
   logic clear;
   int   checks;
   int   errors;

   cpu_datapath_if dif ();
   cpu_datapath dut (.clock(clock), .clear(clear), .bus(dif.slave));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr_ctl();
      dif.Rin = '0; dif.Rout = '0;
      dif.PCin = 0; dif.HIin = 0; dif.LOin = 0; dif.Yin = 0; dif.MARin = 0;
      dif.InPortIn = 0; dif.Zin = 0; dif.MDRin = 0; dif.read = 0; dif.incPC = 0;
      dif.opcode = '0; dif.Mdatain = '0; dif.in_port_data = '0;
      dif.PCout = 0; dif.HIout = 0; dif.LOout = 0; dif.ZHighOut = 0; dif.ZLowOut = 0;
      dif.MDRout = 0; dif.InPortOut = 0;
   endtask

   task automatic do_reset();
      clr_ctl();
      clear = 1'b0;
      tick();
      clear = 1'b1;
   endtask

   task automatic mdr_load(input logic [31:0] v);
      clr_ctl();
      dif.Mdatain = v; dif.read = 1; dif.MDRin = 1;
      tick();
      clr_ctl();
   endtask

   task automatic load_reg(input int idx, input logic [31:0] v);
      mdr_load(v);
      dif.MDRout = 1; dif.Rin[idx] = 1;
      tick();
      clr_ctl();
   endtask

   // Y <= y, R1 <= b, then Z <= ALU(op) with R1 on the bus
   task automatic alu_run(input logic [31:0] y, input logic [31:0] b, input logic [4:0] op);
      mdr_load(y);
      dif.MDRout = 1; dif.Yin = 1;
      tick();
      load_reg(1, b);
      dif.Rout[1] = 1; dif.opcode = op; dif.Zin = 1;
      tick();
      clr_ctl();
   endtask

   task automatic test_reset();
      clr_ctl();
      clear = 1'b0;
      dif.PCout = 1;
      #1;
      checks++; if (dif.bus_out !== 32'd0) begin errors++; $display("FAIL reset_bus got %h exp %h", dif.bus_out, 32'd0); end
      checks++; if (dif.mar_out !== 32'd0) begin errors++; $display("FAIL reset_mar got %h exp %h", dif.mar_out, 32'd0); end
      checks++; if (dif.pc_out  !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", dif.pc_out, 32'd0); end
      tick();
      clear = 1'b1;
      clr_ctl();
   endtask

   task automatic test_load();
      load_reg(3, 32'd30);
      load_reg(7, 32'd25);
      load_reg(4, 32'd10);
      dif.Rout[3] = 1; #1;
      checks++; if (dif.bus_out !== 32'd30) begin errors++; $display("FAIL load_r3 got %0d exp %0d", dif.bus_out, 30); end
      clr_ctl(); dif.Rout[7] = 1; #1;
      checks++; if (dif.bus_out !== 32'd25) begin errors++; $display("FAIL load_r7 got %0d exp %0d", dif.bus_out, 25); end
      clr_ctl(); dif.Rout[4] = 1; #1;
      checks++; if (dif.bus_out !== 32'd10) begin errors++; $display("FAIL load_r4 got %0d exp %0d", dif.bus_out, 10); end
      clr_ctl();
   endtask

   task automatic test_add();
      dif.Rout[3] = 1; dif.Yin = 1; tick(); clr_ctl();
      dif.Rout[7] = 1; dif.opcode = 5'b00011; dif.Zin = 1; tick(); clr_ctl();
      dif.ZLowOut = 1; dif.Rin[4] = 1; tick(); clr_ctl();
      dif.Rout[4] = 1; #1;
      checks++; if (dif.bus_out !== 32'd55) begin errors++; $display("FAIL add_r4 got %0d exp %0d", dif.bus_out, 55); end
      clr_ctl(); dif.ZHighOut = 1; #1;
      checks++; if (dif.bus_out !== 32'd0) begin errors++; $display("FAIL add_zhigh got %h exp %h", dif.bus_out, 32'd0); end
      clr_ctl();
   endtask

   task automatic test_pc_mar();
      do_reset();
      dif.PCout = 1; dif.MARin = 1; dif.incPC = 1; tick(); clr_ctl();
      checks++; if (dif.mar_out !== 32'd0) begin errors++; $display("FAIL pc_mar_mar got %h exp %h", dif.mar_out, 32'd0); end
      checks++; if (dif.pc_out  !== 32'd1) begin errors++; $display("FAIL pc_mar_inc got %h exp %h", dif.pc_out, 32'd1); end
      mdr_load(32'h0000_0003);
      dif.MDRout = 1; dif.PCin = 1; tick(); clr_ctl();
      checks++; if (dif.pc_out !== 32'd3) begin errors++; $display("FAIL pc_load got %h exp %h", dif.pc_out, 32'd3); end
      mdr_load(32'd5);
      dif.MDRout = 1; dif.PCin = 1; dif.incPC = 1; tick(); clr_ctl();
      checks++; if (dif.pc_out !== 32'd5) begin errors++; $display("FAIL pc_prio got %h exp %h", dif.pc_out, 32'd5); end
      mdr_load(32'hFFFF_FFFF);
      dif.MDRout = 1; dif.PCin = 1; tick(); clr_ctl();
      dif.incPC = 1; tick(); clr_ctl();
      checks++; if (dif.pc_out !== 32'd0) begin errors++; $display("FAIL pc_wrap got %h exp %h", dif.pc_out, 32'd0); end
   endtask

   task automatic test_alu();
      logic [31:0] ylist [9];
      logic [31:0] blist [9];
      logic [4:0]  olist [9];
      logic [31:0] elist [9];
      ylist = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'd5,        32'h0000_F0F0, 32'h0000_F0F0, 32'd0,        32'd7};
      blist = '{32'd4,         32'd4,         32'd4,         32'd4,         32'd7,        32'h0000_0FF0, 32'h0000_0FF0, 32'd1,        32'd9};
      olist = '{5'b01000,      5'b01011,      5'b00111,      5'b01010,      5'b00100,     5'b00101,      5'b00110,      5'b10001,     5'b11111};
      elist = '{32'hF800_0000, 32'h0000_0018, 32'h0800_0000, 32'h1800_0000, 32'hFFFF_FFFE, 32'h0000_00F0, 32'h0000_FFF0, 32'hFFFF_FFFF, 32'd0};
      for (int i = 0; i < 9; i++) begin
         alu_run(ylist[i], blist[i], olist[i]);
         dif.ZLowOut = 1; #1;
         checks++; if (dif.bus_out !== elist[i]) begin errors++; $display("FAIL alu_op%b got %h exp %h", olist[i], dif.bus_out, elist[i]); end
         clr_ctl();
      end
      alu_run(32'd0, 32'h1234_5678, 5'b10010);
      dif.ZLowOut = 1; #1;
      checks++; if (dif.bus_out !== 32'hEDCB_A987) begin errors++; $display("FAIL alu_not got %h exp %h", dif.bus_out, 32'hEDCB_A987); end
      clr_ctl();
   endtask

   task automatic test_muldiv();
      logic [63:0] exp_mul, exp_div, exp_dz;
`ifdef ALU_MULDIV_EN
      exp_mul = 64'hFFFF_FFFF_FFFF_FFE8;
      exp_div = {32'd2, 32'd3};
`else
      exp_mul = 64'd0;
      exp_div = 64'd0;
`endif
      exp_dz = 64'd0;
      alu_run(32'hFFFF_FFFA, 32'd4, 5'b01111);
      dif.ZHighOut = 1; #1;
      checks++; if (dif.bus_out !== exp_mul[63:32]) begin errors++; $display("FAIL mul_hi got %h exp %h", dif.bus_out, exp_mul[63:32]); end
      clr_ctl(); dif.ZLowOut = 1; #1;
      checks++; if (dif.bus_out !== exp_mul[31:0]) begin errors++; $display("FAIL mul_lo got %h exp %h", dif.bus_out, exp_mul[31:0]); end
      clr_ctl();
      alu_run(32'd17, 32'd5, 5'b10000);
      dif.ZLowOut = 1; #1;
      checks++; if (dif.bus_out !== exp_div[31:0]) begin errors++; $display("FAIL div_quot got %h exp %h", dif.bus_out, exp_div[31:0]); end
      clr_ctl(); dif.ZHighOut = 1; #1;
      checks++; if (dif.bus_out !== exp_div[63:32]) begin errors++; $display("FAIL div_rem got %h exp %h", dif.bus_out, exp_div[63:32]); end
      clr_ctl();
      alu_run(32'd17, 32'd0, 5'b10000);
      dif.ZLowOut = 1; #1;
      checks++; if (dif.bus_out !== exp_dz[31:0]) begin errors++; $display("FAIL div0_lo got %h exp %h", dif.bus_out, exp_dz[31:0]); end
      clr_ctl(); dif.ZHighOut = 1; #1;
      checks++; if (dif.bus_out !== exp_dz[63:32]) begin errors++; $display("FAIL div0_hi got %h exp %h", dif.bus_out, exp_dz[63:32]); end
      clr_ctl();
   endtask

   task automatic test_misc_regs();
      dif.in_port_data = 32'h0000_CAFE; dif.InPortIn = 1; tick(); clr_ctl();
      dif.InPortOut = 1; dif.HIin = 1; dif.LOin = 1; tick(); clr_ctl();
      dif.InPortOut = 1; #1;
      checks++; if (dif.bus_out !== 32'h0000_CAFE) begin errors++; $display("FAIL inport got %h exp %h", dif.bus_out, 32'h0000_CAFE); end
      clr_ctl(); dif.HIout = 1; #1;
      checks++; if (dif.bus_out !== 32'h0000_CAFE) begin errors++; $display("FAIL multi_hi got %h exp %h", dif.bus_out, 32'h0000_CAFE); end
      clr_ctl(); dif.LOout = 1; #1;
      checks++; if (dif.bus_out !== 32'h0000_CAFE) begin errors++; $display("FAIL multi_lo got %h exp %h", dif.bus_out, 32'h0000_CAFE); end
      clr_ctl();
      mdr_load(32'h0000_1111);
      dif.MDRout = 1; dif.read = 0; dif.MDRin = 1; dif.Mdatain = 32'h2222_2222; tick(); clr_ctl();
      dif.MDRout = 1; #1;
      checks++; if (dif.bus_out !== 32'h0000_1111) begin errors++; $display("FAIL mdr_from_bus got %h exp %h", dif.bus_out, 32'h0000_1111); end
      clr_ctl();
   endtask

   task automatic test_priority();
      load_reg(2, 32'h0000_1234);
      mdr_load(32'h0000_ABCD);
      dif.Rout[2] = 1; dif.MDRout = 1; #1;
      checks++; if (dif.bus_out !== 32'h0000_1234) begin errors++; $display("FAIL prio_r2_mdr got %h exp %h", dif.bus_out, 32'h0000_1234); end
      clr_ctl();
      load_reg(9, 32'h0000_0099);
      dif.Rout[9] = 1; dif.PCout = 1; dif.ZLowOut = 1; #1;
      checks++; if (dif.bus_out !== 32'h0000_0099) begin errors++; $display("FAIL prio_r9_pc got %h exp %h", dif.bus_out, 32'h0000_0099); end
      clr_ctl();
      dif.Rout[2] = 1; dif.Rin[2] = 1; tick(); clr_ctl();
      dif.Rout[2] = 1; #1;
      checks++; if (dif.bus_out !== 32'h0000_1234) begin errors++; $display("FAIL self_xfer got %h exp %h", dif.bus_out, 32'h0000_1234); end
      clr_ctl();
      #1;
      checks++; if (dif.bus_out !== 32'd0) begin errors++; $display("FAIL idle_bus got %h exp %h", dif.bus_out, 32'd0); end
   endtask

   task automatic test_async_reset();
      load_reg(3, 32'd7);
      mdr_load(32'h0000_0055);
      dif.MDRout = 1; dif.PCin = 1; dif.MARin = 1; tick(); clr_ctl();
      dif.Rout[3] = 1;
      #2;
      clear = 1'b0;
      #1;
      checks++; if (dif.pc_out  !== 32'd0) begin errors++; $display("FAIL areset_pc got %h exp %h", dif.pc_out, 32'd0); end
      checks++; if (dif.mar_out !== 32'd0) begin errors++; $display("FAIL areset_mar got %h exp %h", dif.mar_out, 32'd0); end
      checks++; if (dif.bus_out !== 32'd0) begin errors++; $display("FAIL areset_bus got %h exp %h", dif.bus_out, 32'd0); end
      tick();
      clear = 1'b1;
      clr_ctl();
      dif.PCout = 1; dif.MARin = 1; dif.incPC = 1; tick(); clr_ctl();
      checks++; if (dif.pc_out !== 32'd1) begin errors++; $display("FAIL areset_after_pc got %h exp %h", dif.pc_out, 32'd1); end
      checks++; if (dif.mar_out !== 32'd0) begin errors++; $display("FAIL areset_after_mar got %h exp %h", dif.mar_out, 32'd0); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear  = 1'b0;
      clr_ctl();
      #1;
      test_reset();
      test_load();
      test_add();
      test_pc_mar();
      test_alu();
      test_muldiv();
      test_misc_regs();
      test_priority();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
